// File: rtl/fb_write_ctrl.sv
// Write-side stage for the VGA frame RAM: accepts word writes, range-checks and queues them,
// and commits them only while blank_b is low. Define FB_WRITE_CTRL_STATS_EN to add drop_cnt/wr_cnt.
module fb_write_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'd10000,
    parameter logic [31:0] FB_WORDS  = 32'd19200,
    parameter int          RAM_AW    = 15,
    parameter int          DW        = 32,
    parameter int          DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic [DW-1:0]          req_data,
    input  logic                   blank_b,
    output logic                   ram_we,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [DW-1:0]          ram_wdata,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy
`ifdef FB_WRITE_CTRL_STATS_EN
    ,
    output logic [15:0]            drop_cnt,
    output logic [31:0]            wr_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = RAM_AW + DW;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_BLANK, DRAIN} state_t;

    state_t            state_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [EW-1:0]     mem [DEPTH];
    logic              ram_we_reg;
    logic [RAM_AW-1:0] ram_addr_reg;
    logic [DW-1:0]     ram_wdata_reg;

    logic [31:0] off;
    logic        in_range;
    logic        accept;
    logic        push;
    logic        pop;

    assign off       = req_addr - BASE_ADDR;
    assign in_range  = (req_addr >= BASE_ADDR) && (off < FB_WORDS);
    assign req_ready = en && !rst && (level_reg < FULL_LEVEL);
    assign accept    = req_valid && req_ready;
    // Out-of-range requests complete the handshake but never occupy a slot.
    assign push      = accept && in_range;
    // The WAIT_BLANK->DRAIN edge already pops, giving the two-cycle accept-to-drain latency.
    assign pop       = (state_reg != IDLE) && (level_reg != '0) && !blank_b && en;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + 1'b1;
        end else if (pop && !push) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {off[RAM_AW-1:0], req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            level_reg  <= level_next;
            ram_we_reg <= pop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg                      <= rd_ptr_reg + 1'b1;
                {ram_addr_reg, ram_wdata_reg}   <= mem[rd_ptr_reg];
            end
            case (state_reg)
                IDLE: begin
                    if ((level_reg != '0) && en) begin
                        state_reg <= WAIT_BLANK;
                    end
                end
                WAIT_BLANK: begin
                    if (pop) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level_next == '0) begin
                        state_reg <= IDLE;
                    end else if (blank_b || !en) begin
                        state_reg <= WAIT_BLANK;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign fifo_level = level_reg;
    assign busy       = (level_reg != '0) || (state_reg != IDLE);

`ifdef FB_WRITE_CTRL_STATS_EN
    logic [15:0] drop_cnt_reg;
    logic [31:0] wr_cnt_reg;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
            wr_cnt_reg   <= '0;
        end else begin
            if (accept && !in_range && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (ram_we_reg && (wr_cnt_reg != '1)) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
        end
    end

    assign drop_cnt = drop_cnt_reg;
    assign wr_cnt   = wr_cnt_reg;
`endif

endmodule
